// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, selects the next PC, runs the
// req/ready handshake to instruction memory and presents one fetched word
// to the IF/ID register, holding it while ID stalls.
// Optional interrupt entry is enabled by defining IF_IRQ_EN (adds irq/epc).
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000
`ifdef IF_IRQ_EN
    ,
    parameter logic [31:0] IRQ_VECTOR = 32'h8000_0004
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction,
    output logic        if_valid,
    output logic        id_flush
`ifdef IF_IRQ_EN
    ,
    input  logic        irq,
    output logic [31:0] epc
`endif
);

    // ISSUE: may start a request; WAIT: request outstanding for live PC;
    // DROP: request outstanding for a PC made stale by a redirect.
    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_WAIT  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] req_addr;
    logic [31:0] instr_q;
    logic [31:0] target;
    logic        redirect;
    logic        ctrl_redirect;
    logic        issue_ok;
    logic        capture;
`ifdef IF_IRQ_EN
    logic        irq_take;
`endif

    // Redirect selection with fixed priority; targets are word-aligned here.
    always_comb begin
        ctrl_redirect = branch_taken | jr | jump;
        target        = 32'h0;
        if (branch_taken)
            target = branch_target;
        else if (jr)
            target = jr_target;
        else if (jump)
            target = jump_target;
`ifdef IF_IRQ_EN
        // Interrupts are only taken from user space (pc[31]==0) and lose
        // to every control-flow redirect.
        irq_take = irq && !ctrl_redirect && !pc[31];
        if (irq_take)
            target = IRQ_VECTOR;
        redirect = ctrl_redirect | irq_take;
`else
        redirect = ctrl_redirect;
`endif
        target   = target & ~32'h3;
        id_flush = redirect;
    end

    // Handshake FSM: request generation, next state and capture decision.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        imem_addr  = req_addr;
        // A new fetch may start only when the output slot is free.
        issue_ok   = reset && (!stall || !if_valid);
        case (state)
            S_ISSUE: begin
                imem_addr = pc;
                imem_req  = issue_ok;
                if (issue_ok && !imem_ready)
                    state_next = redirect ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                imem_req = reset;
                if (imem_ready)
                    state_next = S_ISSUE;
                else if (redirect)
                    state_next = S_DROP;
            end
            S_DROP: begin
                imem_req = reset;
                if (imem_ready)
                    state_next = S_ISSUE;
            end
            default: begin
                state_next = S_ISSUE;
            end
        endcase
        // A response is kept only for a live request and only if no
        // redirect is competing with it in the same cycle.
        capture = imem_req && imem_ready && !redirect && (state != S_DROP);
    end

    // Next PC: redirect wins, otherwise advance past a captured word.
    always_comb begin
        pc_next = pc;
        if (redirect)
            pc_next = target;
        else if (capture)
            pc_next = pc + 32'd4;
    end

    // State, PC and the held request address (stable while outstanding).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_ISSUE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (state == S_ISSUE)
                req_addr <= pc;
        end
    end

    // Presented instruction slot toward IF/ID.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_valid <= 1'b0;
            if_pc    <= 32'h0;
            instr_q  <= 32'h0;
        end else if (redirect) begin
            if_valid <= 1'b0;
        end else if (capture) begin
            if_valid <= 1'b1;
            if_pc    <= pc + 32'd4;
            instr_q  <= imem_rdata;
        end else if (if_valid && !stall) begin
            if_valid <= 1'b0;
        end
    end

    assign if_instruction = if_valid ? instr_q : 32'h0;

`ifdef IF_IRQ_EN
    // Saved return PC: the next instruction that has not been issued yet.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            epc <= 32'h0;
        else if (irq_take)
            epc <= pc;
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed sequences, a redirect
// priority table and a randomized run against a transaction-level model.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        jr = 1'b0;
    logic [31:0] jr_target = 32'h0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        if_valid;
    logic        id_flush;
`ifdef IF_IRQ_EN
    logic        irq = 1'b0;
    logic [31:0] epc;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Instruction memory contents as a fixed function of the address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = mem(imem_addr);

    if_fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jr             (jr),
        .jr_target      (jr_target),
        .jump           (jump),
        .jump_target    (jump_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .if_valid       (if_valid),
        .id_flush       (id_flush)
`ifdef IF_IRQ_EN
        ,
        .irq            (irq),
        .epc            (epc)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    typedef struct {
        logic        b;
        logic        r;
        logic        j;
        logic [31:0] bt;
        logic [31:0] rt;
        logic [31:0] jt;
        logic [31:0] exp;
    } redir_vec_t;

    redir_vec_t vecs[5];

    initial begin
        logic        m_valid;
        logic [31:0] m_instr;
        logic [31:0] m_ifpc;
        logic [31:0] m_pc;
        logic        out_active;
        logic        out_stale;
        logic [31:0] out_addr;
        logic        redir;
        logic        cap;
        logic        exp_req;
        logic [31:0] tgt;
        int          r;

        vecs[0] = '{1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h0000_0500, 32'h0000_0304, 32'h0000_0200, 32'h0000_0304};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_0500, 32'h0000_0304, 32'h0000_0203, 32'h0000_0200};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_0102, 32'h0000_0304, 32'h0000_0200, 32'h0000_0100};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h0000_0500, 32'hFFFF_FFFF, 32'h0000_0200, 32'hFFFF_FFFC};

        // Reset state, then streaming with imem_ready held high.
        imem_ready = 1'b1;
        repeat (2) neg();
        settle();
        chk("rst_req", imem_req, 0);
        chk("rst_valid", if_valid, 0);
        chk("rst_if_pc", if_pc, 0);
        chk("rst_instr", if_instruction, 0);
        neg();
        reset = 1'b1;
        settle();
        chk("s0_req", imem_req, 1);
        chk("s0_addr", imem_addr, 32'h8000_0000);
        chk("s0_flush", id_flush, 0);
        neg();
        chk("s1_valid", if_valid, 1);
        chk("s1_if_pc", if_pc, 32'h8000_0004);
        chk("s1_instr", if_instruction, mem(32'h8000_0000));
        settle();
        chk("s1_addr", imem_addr, 32'h8000_0004);
        neg();
        chk("s2_if_pc", if_pc, 32'h8000_0008);

        // Stall for three cycles with a valid instruction presented.
        stall = 1'b1;
        settle();
        chk("stall_req0", imem_req, 0);
        for (int i = 0; i < 3; i++) begin
            neg();
            chk("stall_if_pc", if_pc, 32'h8000_0008);
            chk("stall_instr", if_instruction, mem(32'h8000_0004));
            chk("stall_valid", if_valid, 1);
            settle();
            chk("stall_req", imem_req, 0);
        end
        stall = 1'b0;
        settle();
        chk("resume_req", imem_req, 1);
        chk("resume_addr", imem_addr, 32'h8000_0008);
        neg();
        chk("resume_if_pc", if_pc, 32'h8000_000C);
        chk("resume_instr", if_instruction, mem(32'h8000_0008));

        // Wait states, then a jump while the request is outstanding.
        imem_ready = 1'b0;
        settle();
        chk("w0_addr", imem_addr, 32'h8000_000C);
        neg();
        chk("w1_valid", if_valid, 0);
        settle();
        chk("w1_req", imem_req, 1);
        chk("w1_addr", imem_addr, 32'h8000_000C);
        neg();
        jump = 1'b1;
        jump_target = 32'h0000_0040;
        settle();
        chk("wj_flush", id_flush, 1);
        chk("wj_addr", imem_addr, 32'h8000_000C);
        neg();
        jump = 1'b0;
        imem_ready = 1'b1;
        settle();
        chk("drop_req", imem_req, 1);
        chk("drop_addr", imem_addr, 32'h8000_000C);
        chk("drop_flush", id_flush, 0);
        neg();
        chk("drop_valid", if_valid, 0);
        settle();
        chk("jmp_addr", imem_addr, 32'h0000_0040);
        neg();
        chk("jmp_valid", if_valid, 1);
        chk("jmp_if_pc", if_pc, 32'h0000_0044);
        chk("jmp_instr", if_instruction, mem(32'h0000_0040));

        // Redirect priority and alignment table.
        for (int i = 0; i < 5; i++) begin
            neg();
            branch_taken  = vecs[i].b;
            jr            = vecs[i].r;
            jump          = vecs[i].j;
            branch_target = vecs[i].bt;
            jr_target     = vecs[i].rt;
            jump_target   = vecs[i].jt;
            settle();
            chk("tbl_flush", id_flush, 1);
            neg();
            branch_taken = 1'b0;
            jr           = 1'b0;
            jump         = 1'b0;
            settle();
            chk("tbl_flush_off", id_flush, 0);
            chk("tbl_valid", if_valid, 0);
            chk("tbl_addr", imem_addr, vecs[i].exp);
        end
        // Last entry left the PC at the top of the address space: wrap.
        neg();
        chk("wrap_if_pc", if_pc, 32'h0000_0000);
        settle();
        chk("wrap_addr", imem_addr, 32'h0000_0000);

`ifdef IF_IRQ_EN
        // Interrupt taken from user space, then masked in kernel space.
        neg();
        imem_ready = 1'b0;
        jump = 1'b1;
        jump_target = 32'h0000_0010;
        neg();
        jump = 1'b0;
        irq = 1'b1;
        settle();
        chk("irq_flush", id_flush, 1);
        neg();
        irq = 1'b0;
        chk("irq_epc", epc, 32'h0000_0010);
        imem_ready = 1'b1;
        neg();
        settle();
        chk("irq_vec_addr", imem_addr, 32'h8000_0004);
        irq = 1'b1;
        settle();
        chk("irq_mask_flush", id_flush, 0);
        neg();
        irq = 1'b0;
        chk("irq_mask_epc", epc, 32'h0000_0010);
`endif

        // Reset asserted while a request is waiting.
        neg();
        imem_ready = 1'b0;
        neg();
        settle();
        chk("rw_req_pre", imem_req, 1);
        reset = 1'b0;
        settle();
        chk("rw_req", imem_req, 0);
        chk("rw_valid", if_valid, 0);
        chk("rw_addr", imem_addr, 32'h8000_0000);
        imem_ready = 1'b1;
        neg();
        chk("rw_late_valid", if_valid, 0);
        imem_ready = 1'b0;
        reset = 1'b1;
        settle();
        chk("rw_rel_req", imem_req, 1);
        chk("rw_rel_addr", imem_addr, 32'h8000_0000);
        neg();
        chk("rw_rel_valid", if_valid, 0);

        // Randomized run against a transaction-level model.
        reset = 1'b0;
        neg();
        settle();
        stall = 1'b0;
        imem_ready = 1'b0;
        reset = 1'b1;
        m_valid    = 1'b0;
        m_instr    = 32'h0;
        m_ifpc     = 32'h0;
        m_pc       = 32'h8000_0000;
        out_active = 1'b0;
        out_stale  = 1'b0;
        out_addr   = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            stall        = ($urandom % 4) == 0;
            imem_ready   = ($urandom % 3) != 0;
            r            = int'($urandom % 16);
            branch_taken = (r == 0) || (r == 3);
            jr           = (r == 1) || (r == 3);
            jump         = (r == 2) || (r == 3);
            branch_target = $urandom;
            jr_target     = $urandom;
            jump_target   = $urandom;
            settle();

            redir = branch_taken | jr | jump;
            tgt   = branch_taken ? branch_target : (jr ? jr_target : jump_target);
            tgt   = tgt & ~32'h3;
            chk("rnd_flush", id_flush, redir);
            if (out_active) begin
                chk("rnd_hold_req", imem_req, 1);
                chk("rnd_hold_addr", imem_addr, out_addr);
            end else begin
                exp_req = !(m_valid && stall);
                chk("rnd_req", imem_req, exp_req);
                if (exp_req)
                    chk("rnd_addr", imem_addr, m_pc);
            end

            if (imem_req && !out_active) begin
                out_active = 1'b1;
                out_stale  = 1'b0;
                out_addr   = imem_addr;
            end
            cap = imem_req && imem_ready && !redir && !out_stale;
            if (out_active && redir)
                out_stale = 1'b1;
            if (imem_req && imem_ready)
                out_active = 1'b0;
            if (redir)
                m_valid = 1'b0;
            else if (cap)
                m_valid = 1'b1;
            else if (m_valid && !stall)
                m_valid = 1'b0;
            if (cap) begin
                m_instr = mem(out_addr);
                m_ifpc  = out_addr + 32'd4;
            end
            if (redir)
                m_pc = tgt;
            else if (cap)
                m_pc = m_pc + 32'd4;

            neg();
            chk("rnd_valid", if_valid, m_valid);
            chk("rnd_instr", if_instruction, m_valid ? m_instr : 32'h0);
            if (m_valid)
                chk("rnd_if_pc", if_pc, m_ifpc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
